// File: rtl/cic_pdm_interpolator_if.sv
// Sample/PDM bus of the CIC interpolator.
// ui_in : [6:0] signed PCM sample, [7] mute
// uo_out: [0] sample clock, [1] PDM, [2] ~PDM, [3] capture strobe, [7:4] zero
interface cic_pdm_interpolator_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  // Sample source / PDM sink side
  modport master (output ui_in, input uo_out);
  // Interpolator side
  modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/cic_pdm_interpolator.sv
// Interpolating CIC (STAGES combs at the sample rate, STAGES integrators at the
// clock rate, zero-stuffed in between) feeding a 1-bit sigma-delta modulator.
// One PCM sample is captured every INTERP clocks; the PDM bit runs at clk.
// Optional: define CIC_PDM_SDM2_EN for a second-order CIFB modulator in place
// of the default first-order one.
module cic_pdm_interpolator #(
  parameter int STAGES     = 3,
  parameter int INTERP     = 12,
  parameter int WIDTH_CTR  = 4,
  parameter int WIDTH_IN   = 7,
  parameter int WIDTH_REGS = WIDTH_IN + STAGES*WIDTH_CTR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cic_pdm_interpolator_if.slave bus
);

  // Modulator arithmetic width: wide enough for the largest accumulator (a2)
  localparam int MW = WIDTH_REGS + 4;
  // Full scale = input full scale times CIC DC gain INTERP^(STAGES-1)
  localparam int FS_I = (2**(WIDTH_IN-1)) * (INTERP**(STAGES-1));
  localparam logic signed [MW-1:0] FS = MW'(FS_I);

  localparam logic [WIDTH_CTR-1:0] CTR_LAST = WIDTH_CTR'(INTERP-1);
  localparam logic [WIDTH_CTR-1:0] CTR_MID  = WIDTH_CTR'(INTERP/2-1);

  // ---------------------------------------------------------------------------
  // Rate counter and sample clock
  // ---------------------------------------------------------------------------
  logic [WIDTH_CTR-1:0] ctr_q, ctr_d;
  logic                 sclk_q, sclk_d;
  logic                 cap;

  assign cap = (ctr_q == CTR_LAST);

  // Counter wraps at INTERP-1; sclk rises mid-period and falls at the capture edge
  always_comb begin
    ctr_d  = cap ? '0 : ctr_q + 1'b1;
    sclk_d = sclk_q;
    if (ctr_q == CTR_MID || cap) sclk_d = ~sclk_q;
  end

  // Counter / sample clock registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      ctr_q  <= ctr_d;
      sclk_q <= sclk_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Input capture and comb section (sample rate)
  // ---------------------------------------------------------------------------
  logic signed [WIDTH_REGS-1:0] sample_ext;
  logic                         mute;
  logic signed [WIDTH_REGS-1:0] x_reg_q, x_reg_d;
  logic signed [WIDTH_REGS-1:0] dly_q   [STAGES];
  logic signed [WIDTH_REGS-1:0] dly_d   [STAGES];
  logic signed [WIDTH_REGS-1:0] comb_in [STAGES];
  logic signed [WIDTH_REGS-1:0] comb_out;
  logic signed [WIDTH_REGS-1:0] u;

  assign sample_ext = {{(WIDTH_REGS-WIDTH_IN){bus.ui_in[WIDTH_IN-1]}},
                       bus.ui_in[WIDTH_IN-1:0]};
  assign mute       = bus.ui_in[7];

  // Comb chain: comb_in[k] is the input of stage k, dly_q[k] its one-sample delay.
  // The chain runs off x_reg_q, so the sample captured at an edge is already
  // differenced in the following ctr==0 cycle.
  always_comb begin
    logic signed [WIDTH_REGS-1:0] acc;
    acc = x_reg_q;
    for (int k = 0; k < STAGES; k++) begin
      comb_in[k] = acc;
      acc        = acc - dly_q[k];
    end
    comb_out = acc;
  end

  // Capture: mute forces zero; comb delays advance on the same edge
  always_comb begin
    x_reg_d = x_reg_q;
    for (int k = 0; k < STAGES; k++) dly_d[k] = dly_q[k];
    if (cap) begin
      x_reg_d = mute ? '0 : sample_ext;
      for (int k = 0; k < STAGES; k++) dly_d[k] = comb_in[k];
    end
  end

  // Zero-stuffing: one comb output per period, zeros elsewhere
  assign u = (ctr_q == '0) ? comb_out : '0;

  // Sample register and comb delays
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg_q <= '0;
      for (int k = 0; k < STAGES; k++) dly_q[k] <= '0;
    end else begin
      x_reg_q <= x_reg_d;
      for (int k = 0; k < STAGES; k++) dly_q[k] <= dly_d[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Integrator section (clock rate); wrap-around is harmless for a CIC
  // ---------------------------------------------------------------------------
  logic signed [WIDTH_REGS-1:0] integ_q [STAGES];
  logic signed [WIDTH_REGS-1:0] integ_d [STAGES];

  // Registered chain: each stage accumulates the previous stage's old value
  always_comb begin
    integ_d[0] = integ_q[0] + u;
    for (int k = 1; k < STAGES; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
  end

  // Integrator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= integ_d[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Sigma-delta modulator
  // ---------------------------------------------------------------------------
  logic                 pdm_q, pdm_d;
  logic signed [MW-1:0] x_w;
  logic signed [MW-1:0] fb_w;

  assign x_w  = {{(MW-WIDTH_REGS){integ_q[STAGES-1][WIDTH_REGS-1]}}, integ_q[STAGES-1]};
  assign fb_w = pdm_q ? FS : -FS;

`ifdef CIC_PDM_SDM2_EN
  logic signed [WIDTH_REGS+1:0] a1_q, a1_d;
  logic signed [MW-1:0]         a2_q, a2_d;
  logic signed [MW-1:0]         a1_n, a2_n;

  // Second-order CIFB: both integrators see the same 1-bit feedback
  always_comb begin
    a1_n  = {{2{a1_q[WIDTH_REGS+1]}}, a1_q} + x_w - fb_w;
    a2_n  = a2_q + a1_n - fb_w;
    a1_d  = a1_n[WIDTH_REGS+1:0];
    a2_d  = a2_n;
    pdm_d = ~a2_n[MW-1];
  end

  // Modulator state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q  <= '0;
      a2_q  <= '0;
      pdm_q <= 1'b0;
    end else begin
      a1_q  <= a1_d;
      a2_q  <= a2_d;
      pdm_q <= pdm_d;
    end
  end
`else
  logic signed [WIDTH_REGS+1:0] e_q, e_d;
  logic signed [MW-1:0]         sum_n;

  // First-order: accumulate error, emit its sign; |e| stays within 2*FS
  always_comb begin
    sum_n = {{2{e_q[WIDTH_REGS+1]}}, e_q} + x_w - fb_w;
    e_d   = sum_n[WIDTH_REGS+1:0];
    pdm_d = ~sum_n[MW-1];
  end

  // Modulator state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q   <= '0;
      pdm_q <= 1'b0;
    end else begin
      e_q   <= e_d;
      pdm_q <= pdm_d;
    end
  end
`endif

  // Strobe is decoded from ctr so it is high for exactly the capture cycle
  assign bus.uo_out = {4'b0000, cap, ~pdm_q, pdm_q, sclk_q};

endmodule

// File: tb/tb_cic_pdm_interpolator.sv
// Directed bench for cic_pdm_interpolator: reset/restart timing, impulse
// response through the CIC, mute timing, and a table of PDM density vectors.
module tb_cic_pdm_interpolator;
  localparam int INTERP = 12;
  localparam int STAGES = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cic_pdm_interpolator_if bus ();
  cic_pdm_interpolator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // PDM bits after edges 1..14 from reset; the first capture reaches pdm at edge 16
`ifdef CIC_PDM_SDM2_EN
  logic pdm_start [14] = '{1,1,0,1,0,0,1,1,0,0,1,1,0,0};
`else
  logic pdm_start [14] = '{1,1,0,1,0,1,0,1,0,1,0,1,0,1};
`endif

  typedef struct {
    logic [7:0] ui;
    int         lo;
    int         hi;
    string      name;
  } dens_t;

  dens_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance until the capture strobe is high (cycle with ctr == INTERP-1)
  task automatic wait_strobe(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2*INTERP; i++) begin
      if (bus.uo_out[3]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: strobe not seen within %0d cycles", name, 2*INTERP);
    end
  endtask

  // Release reset and check strobe/sclk timing and the start of the PDM pattern
  task automatic restart_check(input string tag, input logic [7:0] ui);
    int   first_strobe, nstrobe, mism, side, sclk_hi;
    int   rise [$];
    logic prev_sclk;
    bus.ui_in = ui;
    @(negedge clk);
    rst_n = 1'b1;
    first_strobe = -1; nstrobe = 0; mism = 0; side = 0; sclk_hi = 0;
    prev_sclk = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus.uo_out[3]) begin
        nstrobe++;
        if (first_strobe < 0) first_strobe = n;
      end
      if (bus.uo_out[0] && !prev_sclk) rise.push_back(n);
      prev_sclk = bus.uo_out[0];
      if (n <= 24 && bus.uo_out[0]) sclk_hi++;
      if (n <= 14 && bus.uo_out[1] !== pdm_start[n-1]) mism++;
      if (bus.uo_out[2] !== ~bus.uo_out[1] || bus.uo_out[7:4] !== 4'h0) side++;
    end
    // strobe is high during the 12th clock after release (capture at edge 12)
    check({tag, "_first_strobe"}, first_strobe, INTERP-1);
    check({tag, "_strobe_count"}, nstrobe, 2);
    check({tag, "_sclk_rises"}, rise.size(), 3);
    if (rise.size() == 3) begin
      check({tag, "_sclk_first_rise"}, rise[0], INTERP/2);
      check({tag, "_sclk_period"}, rise[1] - rise[0], INTERP);
    end
    check({tag, "_sclk_duty"}, sclk_hi, INTERP);
    check({tag, "_pdm_start_pattern"}, mism, 0);
    check({tag, "_out_side_bits"}, side, 0);
  endtask

  initial begin
    int v, first_nz, nz, sum, first_val, ones;

    //              ui      lo    hi    name
    tbl[0] = '{8'h95,  599,  601, "mute_density"};   // mute with nonzero sample bits
    tbl[1] = '{8'h00,  599,  601, "zero_density"};
    tbl[2] = '{8'h20,  898,  902, "p32_density"};    // 0.75
    tbl[3] = '{8'h60,  298,  302, "m32_density"};    // 0.25
    tbl[4] = '{8'h10,  748,  752, "p16_density"};    // 0.625
    tbl[5] = '{8'h3F, 1188, 1193, "p63_density"};    // 1190.6
`ifdef CIC_PDM_SDM2_EN
    tbl[6] = '{8'h40,    0,    2, "m64_density"};
`else
    tbl[6] = '{8'h40,    0,    0, "m64_density"};
`endif

    // ---- cold reset with random input ----
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ui_in = 8'($urandom);
      tick();
      check("reset_uo_out", int'(bus.uo_out), 8'h04);
    end
    restart_check("cold", 8'h00);

    // ---- impulse: one +1 sample then zeros ----
    wait_strobe("impulse_wait");
    bus.ui_in = 8'h01;
    tick();                       // capture edge
    bus.ui_in = 8'h00;
    first_nz = -1; nz = 0; sum = 0; first_val = 0; v = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      v = int'(dut.integ_q[STAGES-1]);
      if (v != 0) begin
        if (first_nz < 0) begin
          first_nz  = k;
          first_val = v;
        end
        nz++;
        sum += v;
      end
    end
    check("impulse_first_nonzero", first_nz, STAGES);
    check("impulse_first_value", first_val, 1);
    check("impulse_nonzero_count", nz, STAGES*(INTERP-1)+1);
    check("impulse_sum", sum, INTERP**STAGES);
    check("impulse_final", v, 0);

    // ---- mute timing ----
    wait_strobe("mute_wait");
    bus.ui_in = 8'd20;
    tick();                       // capture 20, ctr -> 0
    repeat (5) tick();            // ctr = 5
    bus.ui_in[7] = 1'b1;
    repeat (4) tick();            // ctr = 9
    bus.ui_in[7] = 1'b0;
    repeat (2) tick();            // ctr = 11
    check("mute_ctr_align", int'(bus.uo_out[3]), 1);
    tick();
    check("mute_mid_period", int'(dut.x_reg_q), 20);
    repeat (9) tick();            // ctr = 9
    bus.ui_in = 8'hFB;            // mute, sample -5
    repeat (2) tick();
    tick();                       // capture with mute held
    check("mute_across_capture", int'(dut.x_reg_q), 0);
    bus.ui_in = 8'h7B;            // -5 unmuted
    wait_strobe("sign_wait");
    tick();
    check("sign_extend_capture", int'(dut.x_reg_q), -5);

    // ---- mid-operation reset ----
    bus.ui_in = 8'd50;
    repeat (100) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_uo_out", int'(bus.uo_out), 8'h04);
    check("midreset_x_reg", int'(dut.x_reg_q), 0);
    check("midreset_integ", int'(dut.integ_q[STAGES-1]), 0);
    @(posedge clk);
    restart_check("warm", 8'd50);

    // ---- density table ----
    for (int t = 0; t < 7; t++) begin
      bus.ui_in = tbl[t].ui;
      repeat (600) tick();
      ones = 0;
      repeat (1200) begin
        tick();
        ones += int'(bus.uo_out[1]);
      end
      check_rng(tbl[t].name, ones, tbl[t].lo, tbl[t].hi);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
